// File: rtl/sld_streamer.sv
// -----------------------------------------------------------------------------
// sld_streamer
//
// Walks the scene ROM from address 0 to LENGTH-1 after a start command.
// Each byte is registered and offered on a valid/ready byte stream toward the
// UART transmitter. An optional idle gap follows every accepted byte except
// the last one. Progress (sent_count) and completion (busy/done) are reported
// to the control logic.
//
// Parameters
//   ADDR_W  ROM address width
//   DATA_W  byte width
//   LENGTH  bytes streamed per run (1 .. 2**ADDR_W)
//   GAP     idle cycles after each accepted byte except the last (0 .. 255)
//
// Ports
//   i_clk         system clock, all state on the rising edge
//   i_rst         asynchronous, active-high reset
//   i_start       run request, honoured only while idle
//   o_rom_addr    ROM read address (registered)
//   i_rom_data    ROM read data, combinational from o_rom_addr
//   o_tx_data     byte offered downstream (registered)
//   o_tx_valid    o_tx_data is valid
//   i_tx_ready    downstream accepts; transfer on valid && ready at an edge
//   o_busy        high whenever the streamer is not idle
//   o_done        one-cycle pulse after the last byte is accepted
//   o_sent_count  bytes accepted in the current / last run
// -----------------------------------------------------------------------------
module sld_streamer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int LENGTH = 251,
   parameter int GAP    = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W:0]   o_sent_count
);

   // sent_count is one bit wider than the address so LENGTH == 2**ADDR_W fits
   localparam logic [ADDR_W:0]   LP_LEN      = (ADDR_W+1)'(LENGTH);
   localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LP_ADDR_ONE = ADDR_W'(1);
   localparam logic [7:0]        LP_GAP      = 8'(GAP);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_tx_valid;
   logic              r_busy;
   logic              r_done;
   logic [ADDR_W:0]   r_sent_count;
   logic [7:0]        r_gap_cnt;

   logic              w_handshake;
   logic [ADDR_W:0]   w_sent_inc;
   logic              w_last;

   assign w_handshake = r_tx_valid & i_tx_ready;
   assign w_sent_inc  = r_sent_count + LP_CNT_ONE;
   assign w_last      = (w_sent_inc == LP_LEN);

   // Streaming FSM: sequences ROM reads, stream handshakes, gaps and completion
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_rom_addr   <= '0;
         r_tx_data    <= '0;
         r_tx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_sent_count <= '0;
         r_gap_cnt    <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_rom_addr   <= '0;
                  r_sent_count <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_LOAD: begin
               // ROM is combinational, so the byte at r_rom_addr is ready now
               r_tx_data  <= i_rom_data;
               r_tx_valid <= 1'b1;
               r_state    <= ST_SEND;
            end

            ST_SEND: begin
               if (w_handshake) begin
                  r_tx_valid   <= 1'b0;
                  r_sent_count <= w_sent_inc;
                  if (w_last) begin
                     // address stays on the last byte; no wrap is possible
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_rom_addr <= r_rom_addr + LP_ADDR_ONE;
                     if (LP_GAP == 8'd0) begin
                        r_state <= ST_LOAD;
                     end else begin
                        r_gap_cnt <= LP_GAP;
                        r_state   <= ST_WAIT;
                     end
                  end
               end else begin
                  r_state <= ST_SEND;
               end
            end

            ST_WAIT: begin
               // leaving on a count of 1 yields exactly GAP idle cycles;
               // <= also guards a stray zero count from a 256-cycle stall
               r_gap_cnt <= r_gap_cnt - 8'd1;
               if (r_gap_cnt <= 8'd1) begin
                  r_state <= ST_LOAD;
               end else begin
                  r_state <= ST_WAIT;
               end
            end

            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_tx_valid <= 1'b0;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rom_addr   = r_rom_addr;
   assign o_tx_data    = r_tx_data;
   assign o_tx_valid   = r_tx_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_sent_count = r_sent_count;

   sld_streamer_chk #(
      .DATA_W (DATA_W)
   ) u_chk (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_tx_valid (r_tx_valid),
      .i_tx_ready (i_tx_ready),
      .i_tx_data  (r_tx_data),
      .i_busy     (r_busy),
      .i_done     (r_done)
   );

endmodule

// -----------------------------------------------------------------------------
// sld_streamer_chk
//
// Protocol properties of the streamer's byte interface and status outputs.
// Has no outputs and no effect on the hardware.
//
// Ports
//   i_clk, i_rst  clock and asynchronous active-high reset of the streamer
//   i_tx_valid    stream valid
//   i_tx_ready    stream ready
//   i_tx_data     stream data
//   i_busy        streamer busy flag
//   i_done        streamer done pulse
// -----------------------------------------------------------------------------
module sld_streamer_chk #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tx_valid,
   input  logic              i_tx_ready,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_busy,
   input  logic              i_done
);

   // an offered byte may not be withdrawn or changed before it is accepted
   a_hold: assert property (@(posedge i_clk) disable iff (i_rst)
      (i_tx_valid && !i_tx_ready) |=> (i_tx_valid && $stable(i_tx_data)));

   a_valid_busy: assert property (@(posedge i_clk) disable iff (i_rst)
      i_tx_valid |-> i_busy);

   a_done_busy: assert property (@(posedge i_clk) disable iff (i_rst)
      i_done |-> i_busy);

   a_done_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
      i_done |=> !i_done);

endmodule

// File: tb/tb_sld_streamer.sv
// -----------------------------------------------------------------------------
// tb_sld_streamer
//
// Directed bench for sld_streamer. Three instances cover LENGTH=251/GAP=0,
// LENGTH=4/GAP=3 and LENGTH=1. The ROM is a computed byte pattern so every
// expected byte comes from the bench's own function.
// -----------------------------------------------------------------------------
module tb_sld_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start [3];
   logic        ready [3];
   logic [11:0] addr  [3];
   logic [7:0]  romd  [3];
   logic [7:0]  txd   [3];
   logic        valid [3];
   logic        busy  [3];
   logic        done  [3];
   logic [12:0] sent  [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [11:0] a);
      logic [11:0] t;
      t = a * 12'd37 + 12'd11;
      return t[7:0] ^ {a[3:0], a[7:4]};
   endfunction

   assign romd[0] = rom_f(addr[0]);
   assign romd[1] = rom_f(addr[1]);
   assign romd[2] = rom_f(addr[2]);

   sld_streamer #(.ADDR_W(12), .DATA_W(8), .LENGTH(251), .GAP(0)) u_d0 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .o_rom_addr(addr[0]),
      .i_rom_data(romd[0]), .o_tx_data(txd[0]), .o_tx_valid(valid[0]),
      .i_tx_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]),
      .o_sent_count(sent[0]));

   sld_streamer #(.ADDR_W(12), .DATA_W(8), .LENGTH(4), .GAP(3)) u_d1 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .o_rom_addr(addr[1]),
      .i_rom_data(romd[1]), .o_tx_data(txd[1]), .o_tx_valid(valid[1]),
      .i_tx_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]),
      .o_sent_count(sent[1]));

   sld_streamer #(.ADDR_W(12), .DATA_W(8), .LENGTH(1), .GAP(0)) u_d2 (
      .i_clk(clk), .i_rst(rst), .i_start(start[2]), .o_rom_addr(addr[2]),
      .i_rom_data(romd[2]), .o_tx_data(txd[2]), .o_tx_valid(valid[2]),
      .i_tx_ready(ready[2]), .o_busy(busy[2]), .o_done(done[2]),
      .o_sent_count(sent[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int d);
      chk("rst_addr",  32'(addr[d]),  32'd0);
      chk("rst_data",  32'(txd[d]),   32'd0);
      chk("rst_valid", 32'(valid[d]), 32'd0);
      chk("rst_busy",  32'(busy[d]),  32'd0);
      chk("rst_done",  32'(done[d]),  32'd0);
      chk("rst_sent",  32'(sent[d]),  32'd0);
   endtask

   // Called at the falling edge right after the start edge. Follows one run
   // to completion, checking bytes, handshake timing (fixed ready), holding
   // under backpressure and the done/busy/count/address end state.
   task automatic run_mon(input int d, input int len, input int gap,
                          input bit rnd, input int poke);
      int         n     = 0;
      int         cyc   = 0;
      int         dones = 0;
      int         vcyc  = 0;
      bit         pv    = 1'b0;
      logic [7:0] pd    = 8'd0;
      chk("start_busy",  32'(busy[d]),  32'd1);
      chk("start_valid", 32'(valid[d]), 32'd0);
      while (n < len && cyc < 3000) begin
         if (pv) begin
            chk("hold_valid", 32'(valid[d]), 32'd1);
            chk("hold_data",  32'(txd[d]),   32'(pd));
         end
         if (done[d]) dones++;
         if (poke >= 0) start[d] = (n == poke);
         ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (valid[d]) vcyc++;
         if (valid[d] && ready[d]) begin
            chk("byte", 32'(txd[d]), 32'(rom_f(12'(n))));
            if (!rnd) chk("hs_edge", cyc + 1, 2 + n * (2 + gap));
            n++;
            pv = 1'b0;
         end else begin
            pv = valid[d];
         end
         pd = txd[d];
         @(negedge clk);
         cyc++;
      end
      if (poke >= 0) start[d] = 1'b0;
      chk("timeout_bytes", n, len);
      chk("early_done",    dones, 0);
      chk("end_done",  32'(done[d]),  32'd1);
      chk("end_busy",  32'(busy[d]),  32'd1);
      chk("end_valid", 32'(valid[d]), 32'd0);
      chk("end_sent",  32'(sent[d]),  32'(len));
      chk("end_addr",  32'(addr[d]),  32'(len - 1));
      if (!rnd) chk("valid_cycles", vcyc, len);
      @(negedge clk);
      chk("post_done", 32'(done[d]), 32'd0);
      chk("post_busy", 32'(busy[d]), 32'd0);
      chk("post_sent", 32'(sent[d]), 32'(len));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_zero(i);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_hold", 32'(busy[0]), 32'd0);

      // run 1: full length, ready high, start poked while busy at byte 10
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      run_mon(0, 251, 0, 1'b0, 10);

      // run 2: start held high restarts right after busy falls
      start[0] = 1'b1;
      @(negedge clk);
      run_mon(0, 251, 0, 1'b0, -1);
      @(negedge clk);
      chk("restart_busy", 32'(busy[0]),  32'd1);
      chk("restart_addr", 32'(addr[0]),  32'd0);
      @(negedge clk);
      start[0] = 1'b0;
      chk("restart_valid", 32'(valid[0]), 32'd1);
      chk("restart_byte",  32'(txd[0]),   32'(rom_f(12'd0)));

      // stream up to byte 100 of the second run, then reset mid-handshake
      n = 0;
      for (int c = 0; c < 1000; c++) begin
         if (valid[0]) begin
            if (n == 100) break;
            n++;
         end
         @(negedge clk);
      end
      chk("abort_reach", n, 100);
      chk("abort_byte",  32'(txd[0]),   32'(rom_f(12'd100)));
      chk("abort_sent",  32'(sent[0]),  32'd100);
      chk("abort_valid", 32'(valid[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_zero(0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done[0]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(busy[0]), 32'd0);

      // run 3: random backpressure, must still stream ROM[0..250] exactly
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      run_mon(0, 251, 0, 1'b1, -1);

      // LENGTH=4, GAP=3: handshakes at 2, 7, 12, 17
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      run_mon(1, 4, 3, 1'b0, -1);

      // LENGTH=1: single byte ROM[0], address stays 0
      start[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      run_mon(2, 1, 0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sld_streamer.md
# sld_streamer

Sequential initiator for the distributed-ROM scene image (`base_sld.mem`, 8-bit words, combinational read). On a start command it walks the ROM from address 0 to LENGTH-1, registers each byte and offers it on a valid/ready byte stream toward the UART transmitter, with optional idle gaps between bytes. It supplies scene data from the core side to the host/loader side, and reports progress and completion to the control logic.

## Interface
- ADDR_W, 12, ROM address width
- DATA_W, 8, byte width
- LENGTH, 251, number of bytes streamed per run; legal range 1..2^ADDR_W
- GAP, 0, idle cycles inserted after each accepted byte except the last; legal range 0..255

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- rom_addr  out  ADDR_W  ROM read address, registered
- rom_data  in  DATA_W  ROM read data, combinational from rom_addr
- tx_data  out  DATA_W  byte offered downstream, registered
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  downstream accepts; transfer when tx_valid && tx_ready at a rising edge
- busy  out  1  high whenever state != IDLE, registered
- done  out  1  one-cycle pulse after the last byte is accepted
- sent_count  out  ADDR_W+1  bytes accepted in the current/last run

## Operation
- States: IDLE, LOAD, SEND, WAIT, DONE.
- IDLE: if start, then rom_addr<=0, sent_count<=0, busy<=1, go to LOAD. Otherwise hold.
- LOAD: tx_data<=rom_data, tx_valid<=1, go to SEND.
- SEND: hold tx_data and tx_valid until tx_ready. On handshake: tx_valid<=0, sent_count<=sent_count+1.
  - If sent_count+1==LENGTH, set done<=1 and go to DONE. rom_addr holds at LENGTH-1.
  - Else rom_addr<=rom_addr+1. Load the gap counter with GAP and go to WAIT, or go straight to LOAD if GAP==0.
- WAIT: decrement the gap counter. When it reaches 1, go to LOAD.
- DONE: done<=0, busy<=0, go to IDLE.
- start is ignored in every state except IDLE; no queuing.
- tx_data must not change while tx_valid is high.
- tx_valid never depends combinationally on tx_ready.
- sent_count holds its final value until the next accepted start.
- Address arithmetic is unsigned ADDR_W. It never wraps because the run stops at LENGTH-1.

## Timing
- Reset value of every output is 0: rom_addr, tx_data, tx_valid, busy, done, sent_count. State is IDLE and the gap counter is 0.
- Reset asserted mid-run aborts immediately, with no done pulse. A pending tx_valid drops asynchronously.
- start sampled at edge k gives busy=1 after k; tx_valid=1 after k+1 with byte ROM[0].
- Per byte, with tx_ready held high: 2+GAP cycles (LOAD, SEND, GAP×WAIT).
- Full run with tx_ready held high: 2·LENGTH + GAP·(LENGTH-1) cycles from start edge to last handshake edge.
  - done is high for the single cycle after the last handshake edge; busy falls together with done.
- The earliest new start is accepted the cycle after busy falls. A start held high continuously restarts automatically at that point.
- Backpressure: each cycle tx_ready is low in SEND adds one cycle and changes nothing else.

## Test plan
- ROM preloaded from base_sld.mem, LENGTH=251, GAP=0, tx_ready=1: 251 bytes equal ROM[0..250] in order.
  - Last handshake occurs 502 cycles after start; single done pulse; sent_count=251; rom_addr=250.
- Random tx_ready (50%) with LENGTH=251: identical byte sequence. tx_data stable while tx_valid && !tx_ready. No byte duplicated or dropped.
- GAP=3, LENGTH=4, tx_ready=1: exactly 3 low-tx_valid cycles between the 1-cycle valid windows (4 beats).
  - Handshakes at cycles 2, 7, 12, 17 after start; done at cycle 18.
- start pulsed while busy (e.g. at byte 10): ignored; run completes with sent_count=251 and one done.
  - With start held high: second run begins the cycle after done and starts again at ROM[0].
- rst asserted while tx_valid is high at byte 100: all outputs 0 immediately, no done.
  - After release, a new start streams from ROM[0].
- LENGTH=1: one byte ROM[0]; done the cycle after its handshake; rom_addr stays 0; sent_count=1.
